note_lane_gen: RTL and testbench

NOTE_LANE_GEN -- requirements
Module: note_lane_gen

---
 rtl/lane_pkg.sv | 28 ++
 rtl/lane_slots.sv | 46 ++++
 rtl/note_lane_gen.sv | 131 +++++++++++++
 tb/tb_note_lane_gen.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/lane_pkg.sv
// Shared colour definitions and score limits for the note lane display.
// Lane colours are indexed by lane number, left to right.
package lane_pkg;

  typedef logic [5:0] rgb_t;

  localparam rgb_t RGB_BLACK     = 6'b000000;
  localparam rgb_t RGB_DIM_WHITE = 6'b010101;
  localparam rgb_t RGB_GREEN     = 6'b001100;
  localparam rgb_t RGB_YELLOW    = 6'b111100;
  localparam rgb_t RGB_BLUE      = 6'b000011;
  localparam rgb_t RGB_ORANGE    = 6'b110100;
  localparam rgb_t RGB_RED       = 6'b110000;

  localparam int SCORE_W   = 14;
  localparam int SCORE_MAX = 9999;

  function automatic rgb_t laneColour(input int lane);
    case (lane)
      0:       laneColour = RGB_GREEN;
      1:       laneColour = RGB_YELLOW;
      2:       laneColour = RGB_BLUE;
      3:       laneColour = RGB_ORANGE;
      default: laneColour = RGB_RED;
    endcase
  endfunction

endpackage

// File: rtl/lane_slots.sv
// One note lane: DEPTH-slot shift register scrolling downward, button edge
// detect, and hit/miss flags for the bottom (hit-zone) slot.
module lane_slots #(
  parameter int DEPTH = 15
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             step_i,
  input  logic             load_i,
  input  logic             button_i,
  output logic [DEPTH-1:0] slots_o,
  output logic             hit_o,
  output logic             miss_o
);

  logic [DEPTH-1:0] slots_q, slots_d;
  logic             button_q;
  logic             buttonRise;

  // A hit clears the zone before any shift, so a simultaneous step never sees it as a miss.
  always_comb begin
    buttonRise = button_i & ~button_q;
    hit_o      = buttonRise & slots_q[DEPTH-1];
    miss_o     = step_i & slots_q[DEPTH-1] & ~hit_o;
    slots_d    = slots_q;
    if (hit_o) begin
      slots_d[DEPTH-1] = 1'b0;
    end
    if (step_i) begin
      slots_d = (slots_d << 1) | DEPTH'(load_i);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      slots_q  <= '0;
      button_q <= 1'b0;
    end else begin
      slots_q  <= slots_d;
      button_q <= button_i;
    end
  end

  assign slots_o = slots_q;

endmodule

// File: rtl/note_lane_gen.sv
// Rhythm-game note lanes: queues note rows, scrolls them once per SCROLL_DIV
// frames, scores button hits in the bottom slot and renders the lanes as pixels.
module note_lane_gen
  import lane_pkg::*;
#(
  parameter int NUM_LANES  = 4,
  parameter int LANE_X0    = 220,
  parameter int LANE_WIDTH = 35,
  parameter int LANE_GAP   = 20,
  parameter int SLOT_LOG2  = 5,
  parameter int DEPTH      = 15,
  parameter int SCROLL_DIV = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [9:0]           col,
  input  logic [9:0]           row,
  input  logic                 valid,
  input  logic                 note_push,
  input  logic [NUM_LANES-1:0] note_lanes,
  input  logic [NUM_LANES-1:0] button,
  output rgb_t                 rgb,
  output logic [SCORE_W-1:0]   score,
  output logic                 hit,
  output logic                 miss
);

  localparam logic [15:0] SCROLL_LAST = 16'(SCROLL_DIV - 1);

  logic                             frameTick, scrollStep;
  logic [15:0]                      scrollCnt_q, scrollCnt_d;
  logic [NUM_LANES-1:0]             pending_q, pending_d;
  logic [NUM_LANES-1:0]             pushLanes, loadLanes, laneHit, laneMiss;
  logic [NUM_LANES-1:0][DEPTH-1:0]  laneSlots;
  logic [SCORE_W-1:0]               score_q, score_d;
  logic [SCORE_W:0]                 scoreSum;
  logic [3:0]                       hitCount;
  logic                             hit_q, miss_q;
  rgb_t                             rgb_q, rgb_d;

  // A push in the same cycle as a scroll step lands directly in slot 0.
  always_comb begin
    frameTick   = (row == 10'd480) && (col == 10'd0);
    scrollStep  = frameTick && (scrollCnt_q == SCROLL_LAST);
    scrollCnt_d = scrollCnt_q;
    if (frameTick) begin
      scrollCnt_d = scrollStep ? 16'd0 : scrollCnt_q + 16'd1;
    end
    pushLanes = note_push ? note_lanes : '0;
    loadLanes = pending_q | pushLanes;
    pending_d = scrollStep ? '0 : loadLanes;
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : gLane
    lane_slots #(
      .DEPTH(DEPTH)
    ) uSlots (
      .clk_i   (clk),
      .reset_i (reset),
      .step_i  (scrollStep),
      .load_i  (loadLanes[g]),
      .button_i(button[g]),
      .slots_o (laneSlots[g]),
      .hit_o   (laneHit[g]),
      .miss_o  (laneMiss[g])
    );
  end

  always_comb begin
    hitCount = 4'd0;
    for (int i = 0; i < NUM_LANES; i++) begin
      hitCount = hitCount + 4'(laneHit[i]);
    end
    scoreSum = {1'b0, score_q} + {11'b0, hitCount};
    score_d  = (scoreSum > 15'(SCORE_MAX)) ? 14'(SCORE_MAX) : scoreSum[SCORE_W-1:0];
  end

  // Pixel colour: a set slot paints the lane colour; empty hit-zone slots are dim white.
  always_comb begin
    logic [31:0] colW, rowW, slotIdx, laneLo;
    logic        noteHere;
    colW     = {22'b0, col};
    rowW     = {22'b0, row};
    slotIdx  = rowW >> SLOT_LOG2;
    laneLo   = 32'd0;
    noteHere = 1'b0;
    rgb_d    = RGB_BLACK;
    if (valid && (slotIdx < 32'(DEPTH))) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        laneLo   = 32'(LANE_X0 + i * (LANE_WIDTH + LANE_GAP));
        noteHere = 1'b0;
        for (int j = 0; j < DEPTH; j++) begin
          if (slotIdx == 32'(j)) begin
            noteHere = laneSlots[i][j];
          end
        end
        if ((colW >= laneLo) && (colW < laneLo + 32'(LANE_WIDTH))) begin
          if (noteHere) begin
            rgb_d = laneColour(i);
          end else if (slotIdx == 32'(DEPTH - 1)) begin
            rgb_d = RGB_DIM_WHITE;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scrollCnt_q <= 16'd0;
      pending_q   <= '0;
      score_q     <= '0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
      rgb_q       <= RGB_BLACK;
    end else begin
      scrollCnt_q <= scrollCnt_d;
      pending_q   <= pending_d;
      score_q     <= score_d;
      hit_q       <= |laneHit;
      miss_q      <= |laneMiss;
      rgb_q       <= rgb_d;
    end
  end

  assign rgb   = rgb_q;
  assign score = score_q;
  assign hit   = hit_q;
  assign miss  = miss_q;

endmodule

// File: tb/tb_note_lane_gen.sv
// Directed self-checking bench for note_lane_gen with one scroll step per frame.
// Frames are compressed: a single cycle at row 480 / col 0 is a frame tick.
module tb_note_lane_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] col, row;
  logic       valid, note_push;
  logic [3:0] note_lanes, button;
  logic [5:0] rgb;
  logic [13:0] score;
  logic       hit, miss;

  int testsRun    = 0;
  int testsFailed = 0;
  int missSeen;

  always #5 clk = ~clk;

  note_lane_gen #(
    .NUM_LANES (4),
    .LANE_X0   (220),
    .LANE_WIDTH(35),
    .LANE_GAP  (20),
    .SLOT_LOG2 (5),
    .DEPTH     (15),
    .SCROLL_DIV(1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .col       (col),
    .row       (row),
    .valid     (valid),
    .note_push (note_push),
    .note_lanes(note_lanes),
    .button    (button),
    .rgb       (rgb),
    .score     (score),
    .hit       (hit),
    .miss      (miss)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // One frame tick (scroll step) with optional note push and button state.
  task automatic applyStimulus(input logic [3:0] pushLanes, input logic [3:0] btn);
    row        = 10'd480;
    col        = 10'd0;
    valid      = 1'b0;
    note_push  = (pushLanes != 4'd0);
    note_lanes = pushLanes;
    button     = btn;
    tick();
    row        = 10'd500;
    note_push  = 1'b0;
    note_lanes = 4'd0;
  endtask

  task automatic checkPixel(input string tag, input logic v, input logic [9:0] r,
                            input logic [9:0] c, input logic [5:0] expected);
    valid = v;
    row   = r;
    col   = c;
    tick();
    checkOutput(tag, 16'(rgb), 16'(expected));
    valid = 1'b0;
    row   = 10'd500;
    col   = 10'd0;
  endtask

  initial begin
    reset = 1'b1; col = 10'd0; row = 10'd500; valid = 1'b0;
    note_push = 1'b0; note_lanes = 4'd0; button = 4'd0;
    tick(); tick();
    checkOutput("reset_rgb", 16'(rgb), 16'd0);
    checkOutput("reset_score", 16'(score), 16'd0);
    checkOutput("reset_hit", 16'(hit), 16'd0);
    checkOutput("reset_miss", 16'(miss), 16'd0);
    reset = 1'b0;
    tick();

    // Queue lane 0, one frame tick loads slot 0.
    note_push = 1'b1; note_lanes = 4'b0001;
    tick();
    note_push = 1'b0; note_lanes = 4'd0;
    applyStimulus(4'd0, 4'd0);
    checkPixel("slot0_green", 1'b1, 10'd0, 10'd221, 6'b001100);
    checkPixel("slot0_corner", 1'b1, 10'd31, 10'd254, 6'b001100);
    checkPixel("lane0_left_edge", 1'b1, 10'd0, 10'd220, 6'b001100);
    checkPixel("lane0_right_out", 1'b1, 10'd0, 10'd255, 6'b000000);
    checkPixel("slot1_empty", 1'b1, 10'd32, 10'd221, 6'b000000);
    checkPixel("lane1_empty", 1'b1, 10'd0, 10'd280, 6'b000000);
    checkPixel("zone_dim_lane1", 1'b1, 10'd448, 10'd280, 6'b010101);
    checkPixel("zone_dim_lane0", 1'b1, 10'd479, 10'd221, 6'b010101);
    checkPixel("below_lanes", 1'b1, 10'd480, 10'd221, 6'b000000);
    checkPixel("invalid_black", 1'b0, 10'd0, 10'd221, 6'b000000);

    // Scroll to the hit zone and hit it.
    for (int k = 0; k < 14; k++) applyStimulus(4'd0, 4'd0);
    checkOutput("no_miss_scroll", 16'(miss), 16'd0);
    checkPixel("zone_note_green", 1'b1, 10'd448, 10'd221, 6'b001100);
    checkPixel("top_now_empty", 1'b1, 10'd0, 10'd221, 6'b000000);
    button = 4'b0001;
    tick();
    checkOutput("hit_pulse", 16'(hit), 16'd1);
    checkOutput("hit_score", 16'(score), 16'd1);
    checkOutput("hit_no_miss", 16'(miss), 16'd0);
    tick();
    checkOutput("hit_single_cycle", 16'(hit), 16'd0);
    button = 4'd0;
    checkPixel("zone_cleared", 1'b1, 10'd448, 10'd221, 6'b010101);

    // Push coincident with a step, then let it fall off for a miss.
    applyStimulus(4'b0010, 4'd0);
    checkPixel("same_cycle_push", 1'b1, 10'd0, 10'd280, 6'b111100);
    for (int k = 0; k < 14; k++) applyStimulus(4'd0, 4'd0);
    checkPixel("zone_yellow", 1'b1, 10'd460, 10'd300, 6'b111100);
    applyStimulus(4'd0, 4'd0);
    checkOutput("miss_pulse", 16'(miss), 16'd1);
    checkOutput("miss_score", 16'(score), 16'd1);
    checkOutput("miss_no_hit", 16'(hit), 16'd0);
    tick();
    checkOutput("miss_single_cycle", 16'(miss), 16'd0);

    // Hit and step in the same cycle: hit wins.
    applyStimulus(4'b0100, 4'd0);
    for (int k = 0; k < 14; k++) applyStimulus(4'd0, 4'd0);
    applyStimulus(4'd0, 4'b0100);
    checkOutput("prio_hit", 16'(hit), 16'd1);
    checkOutput("prio_no_miss", 16'(miss), 16'd0);
    checkOutput("prio_score", 16'(score), 16'd2);
    button = 4'd0;
    applyStimulus(4'd0, 4'd0);
    checkOutput("prio_next_no_miss", 16'(miss), 16'd0);

    // Button on an empty hit zone does nothing.
    button = 4'b1000;
    tick();
    checkOutput("empty_zone_hit", 16'(hit), 16'd0);
    checkOutput("empty_zone_score", 16'(score), 16'd2);
    button = 4'd0;
    tick();

    // Three lanes hit together.
    applyStimulus(4'b1011, 4'd0);
    for (int k = 0; k < 14; k++) applyStimulus(4'd0, 4'd0);
    button = 4'b1011;
    tick();
    checkOutput("multi_hit", 16'(hit), 16'd1);
    checkOutput("multi_score", 16'(score), 16'd5);
    button = 4'd0;
    tick();

    // Fill every slot and hit all four lanes each step up to saturation.
    missSeen = 0;
    for (int k = 0; k < 14; k++) applyStimulus(4'hF, 4'd0);
    for (int k = 0; k < 2499; k++) begin
      applyStimulus(4'hF, 4'd0);
      if (miss) missSeen++;
      button = 4'hF;
      tick();
      if (k == 2497) checkOutput("pre_sat_score", 16'(score), 16'd9997);
      button = 4'd0;
      tick();
    end
    checkOutput("sat_score", 16'(score), 16'd9999);
    checkOutput("sat_no_misses", 16'(missSeen), 16'd0);
    applyStimulus(4'hF, 4'd0);
    button = 4'hF;
    tick();
    checkOutput("sat_hit_pulse", 16'(hit), 16'd1);
    checkOutput("sat_score_held", 16'(score), 16'd9999);
    button = 4'd0;
    tick();

    // Reset mid-frame with lanes full and a note pending.
    note_push = 1'b1; note_lanes = 4'b0001;
    valid = 1'b1; row = 10'd200; col = 10'd230;
    tick();
    note_push = 1'b0; note_lanes = 4'd0;
    checkOutput("prereset_green", 16'(rgb), 16'b001100);
    reset = 1'b1;
    #1;
    checkOutput("midreset_rgb", 16'(rgb), 16'd0);
    checkOutput("midreset_score", 16'(score), 16'd0);
    checkOutput("midreset_hit", 16'(hit), 16'd0);
    tick();
    reset = 1'b0;
    valid = 1'b0; row = 10'd500; col = 10'd0;
    tick();
    checkPixel("post_reset_top", 1'b1, 10'd200, 10'd230, 6'b000000);
    checkPixel("post_reset_zone0", 1'b1, 10'd448, 10'd221, 6'b010101);
    checkPixel("post_reset_zone3", 1'b1, 10'd448, 10'd400, 6'b010101);
    applyStimulus(4'd0, 4'd0);
    checkOutput("post_reset_no_miss", 16'(miss), 16'd0);
    checkPixel("pending_cleared", 1'b1, 10'd0, 10'd221, 6'b000000);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
